// File: rtl/ntt_basemul.sv
// ntt_basemul: pointwise product of two NTT-domain Kyber polynomials.
// For each of the 128 coefficient pairs it computes the degree-1 product modulo X^2 - gamma_i:
//   h[2i]   = (a0*b0 + ((a1*b1) mod Q) * gamma_i) mod Q
//   h[2i+1] = (a0*b1 + a1*b0) mod Q
// One pair is handled per three cycles (MUL -> GAM -> WR), so a full run takes 385 cycles.
// Ports:
//   clk, reset       clock, asynchronous active-high reset
//   start            begin a run; only sampled while idle
//   f_hat, g_hat     operands, 256 coefficients in [0, Q-1]; must stay stable until done
//   h_hat            product, 256 coefficients in [0, Q-1]; unwritten entries keep old values
//   busy             high whenever the FSM is not idle
//   done             one-cycle pulse once h_hat is complete
module ntt_basemul #(
  parameter int unsigned N = 256,
  parameter int unsigned Q = 3329
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               start,
  input  logic signed [15:0] f_hat [N],
  input  logic signed [15:0] g_hat [N],
  output logic signed [15:0] h_hat [N],
  output logic               busy,
  output logic               done
);

  typedef enum logic [2:0] {StIdle, StMul, StGam, StWr, StDone} state_e;

  // gamma_k = 17^(2*BitRev7(k)+1) mod Q, evaluated at elaboration time.
  function automatic logic [11:0] gamma_calc(input int unsigned k);
    int unsigned brv;
    int unsigned e;
    int unsigned r;
    int unsigned b;
    brv = 0;
    for (int j = 0; j < 7; j++) begin
      if (((k >> j) & 1) != 0) brv = brv | (1 << (6 - j));
    end
    e = 2 * brv + 1;
    r = 1;
    b = 17;
    for (int j = 0; j < 8; j++) begin
      if (((e >> j) & 1) != 0) r = (r * b) % Q;
      b = (b * b) % Q;
    end
    return 12'(r);
  endfunction

  logic [11:0] gamma_tab [128];
  for (genvar k = 0; k < 128; k++) begin : g_gamma
    localparam logic [11:0] Gamma = gamma_calc(k);
    assign gamma_tab[k] = Gamma;
  end

  state_e      state_q, state_d;
  logic [6:0]  i_q;
  logic [23:0] p00_q, p11_q, p01_q, p10_q, t_q;
  logic [11:0] h_q [N];
  logic        done_q;

  logic        mul_en, gam_en, wr_en, done_set, accept;

  // State register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) state_q <= StIdle;
    else       state_q <= state_d;
  end

  // Next-state logic.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle:  if (start) state_d = StMul;
      StMul:   state_d = StGam;
      StGam:   state_d = StWr;
      StWr:    state_d = (i_q == 7'd127) ? StDone : StMul;
      StDone:  state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  // Output / enable decode.
  always_comb begin
    busy     = (state_q != StIdle);
    accept   = (state_q == StIdle) && start;
    mul_en   = (state_q == StMul);
    gam_en   = (state_q == StGam);
    wr_en    = (state_q == StWr);
    done_set = (state_q == StDone);
    done     = done_q;
  end

  // Operand fetch for the current pair; inputs are in [0, Q-1] so 12 bits suffice.
  logic [7:0]  idx_even, idx_odd;
  logic [11:0] a0, a1, b0, b1;
  logic [11:0] p11_red;
  logic [23:0] t_d;
  logic [24:0] sum_even, sum_odd;
  logic [11:0] h_even, h_odd;

  always_comb begin
    idx_even = {i_q, 1'b0};
    idx_odd  = {i_q, 1'b1};
    a0       = 12'(f_hat[idx_even]);
    a1       = 12'(f_hat[idx_odd]);
    b0       = 12'(g_hat[idx_even]);
    b1       = 12'(g_hat[idx_odd]);
    p11_red  = 12'(p11_q % 24'(Q));
    t_d      = 24'(p11_red) * 24'(gamma_tab[i_q]);
    sum_even = {1'b0, p00_q} + {1'b0, t_q};
    sum_odd  = {1'b0, p01_q} + {1'b0, p10_q};
    h_even   = 12'(sum_even % 25'(Q));
    h_odd    = 12'(sum_odd % 25'(Q));
  end

  // Datapath registers. Products stay put through GAM and WR since MUL is the only writer.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      i_q    <= '0;
      p00_q  <= '0;
      p11_q  <= '0;
      p01_q  <= '0;
      p10_q  <= '0;
      t_q    <= '0;
      done_q <= 1'b0;
      for (int k = 0; k < N; k++) h_q[k] <= '0;
    end else begin
      done_q <= done_set;
      if (accept) i_q <= '0;
      else if (wr_en && (i_q != 7'd127)) i_q <= i_q + 7'd1;
      if (mul_en) begin
        p00_q <= 24'(a0) * 24'(b0);
        p11_q <= 24'(a1) * 24'(b1);
        p01_q <= 24'(a0) * 24'(b1);
        p10_q <= 24'(a1) * 24'(b0);
      end
      if (gam_en) t_q <= t_d;
      if (wr_en) begin
        h_q[idx_even] <= h_even;
        h_q[idx_odd]  <= h_odd;
      end
    end
  end

  always_comb begin
    for (int k = 0; k < N; k++) h_hat[k] = {4'b0000, h_q[k]};
  end

endmodule

// File: tb/tb_ntt_basemul.sv
module tb_ntt_basemul;

  logic               clk;
  logic               reset;
  logic               start;
  logic signed [15:0] f [256];
  logic signed [15:0] g [256];
  logic signed [15:0] h [256];
  logic               busy;
  logic               done;

  logic signed [15:0] exp_h [256];
  int                 pass_cnt;
  int                 total_cnt;

  ntt_basemul dut (
    .clk   (clk),
    .reset (reset),
    .start (start),
    .f_hat (f),
    .g_hat (g),
    .h_hat (h),
    .busy  (busy),
    .done  (done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference gamma by repeated multiplication.
  function automatic int gamma_ref(input int i);
    int brv;
    int r;
    brv = 0;
    for (int b = 0; b < 7; b++) brv = brv | (((i >> b) & 1) << (6 - b));
    r = 1;
    for (int e = 0; e < 2 * brv + 1; e++) r = (r * 17) % 3329;
    return r;
  endfunction

  task automatic clear_vectors();
    for (int k = 0; k < 256; k++) begin
      f[k]     = '0;
      g[k]     = '0;
      exp_h[k] = '0;
    end
  endtask

  // Pulse start, then count edges after E0 until done is seen (bounded).
  task automatic run_job(output int lat, output logic busy_after_e0);
    @(negedge clk);
    start = 1'b1;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    busy_after_e0 = busy;
    lat = 0;
    while (!done && lat < 1000) begin
      @(posedge clk);
      lat++;
      @(negedge clk);
    end
  endtask

  task automatic test_reset();
    int bad;
    reset = 1'b1;
    start = 1'b0;
    clear_vectors();
    repeat (3) @(negedge clk);
    total_cnt++;
    if (busy !== 1'b0) $display("FAIL reset_busy: got %b required 0", busy);
    else pass_cnt++;
    total_cnt++;
    if (done !== 1'b0) $display("FAIL reset_done: got %b required 0", done);
    else pass_cnt++;
    bad = -1;
    for (int k = 0; k < 256; k++) if (bad < 0 && h[k] !== 16'sd0) bad = k;
    total_cnt++;
    if (bad >= 0) $display("FAIL reset_h: h[%0d]=%0d required 0", bad, h[bad]);
    else pass_cnt++;
    reset = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_unit();
    int   lat;
    int   bad;
    logic b0;
    clear_vectors();
    f[0] = 16'sd1;
    g[0] = 16'sd1;
    exp_h[0] = 16'sd1;
    run_job(lat, b0);
    total_cnt++;
    if (b0 !== 1'b1) $display("FAIL unit_busy_rise: got %b required 1", b0);
    else pass_cnt++;
    total_cnt++;
    if (lat != 385) $display("FAIL unit_latency: got %0d cycles required 385", lat);
    else pass_cnt++;
    total_cnt++;
    if (busy !== 1'b0) $display("FAIL unit_busy_at_done: got %b required 0", busy);
    else pass_cnt++;
    bad = -1;
    for (int k = 0; k < 256; k++) if (bad < 0 && h[k] !== exp_h[k]) bad = k;
    total_cnt++;
    if (bad >= 0) $display("FAIL unit_h: h[%0d]=%0d required %0d", bad, h[bad], exp_h[bad]);
    else pass_cnt++;
    @(negedge clk);
    total_cnt++;
    if (done !== 1'b0) $display("FAIL unit_done_width: got %b required 0", done);
    else pass_cnt++;
  endtask

  task automatic test_gamma_pairs();
    int   lat;
    int   bad;
    logic b0;
    clear_vectors();
    f[1] = 16'sd1; g[1] = 16'sd1;
    f[3] = 16'sd1; g[3] = 16'sd1;
    exp_h[0] = 16'sd17;
    exp_h[2] = 16'sd3312;
    run_job(lat, b0);
    total_cnt++;
    if (h[0] !== 16'sd17) $display("FAIL gp_h0: got %0d required 17", h[0]);
    else pass_cnt++;
    total_cnt++;
    if (h[2] !== 16'sd3312) $display("FAIL gp_h2: got %0d required 3312", h[2]);
    else pass_cnt++;
    bad = -1;
    for (int k = 0; k < 256; k++) if (bad < 0 && h[k] !== exp_h[k]) bad = k;
    total_cnt++;
    if (bad >= 0) $display("FAIL gp_h: h[%0d]=%0d required %0d", bad, h[bad], exp_h[bad]);
    else pass_cnt++;
  endtask

  task automatic load_small();
    clear_vectors();
    f[0] = 16'sd1; f[1] = 16'sd2;
    g[0] = 16'sd3; g[1] = 16'sd4;
    exp_h[0] = 16'sd139;
    exp_h[1] = 16'sd10;
  endtask

  task automatic test_small();
    int   lat;
    int   bad;
    logic b0;
    load_small();
    run_job(lat, b0);
    total_cnt++;
    if (h[0] !== 16'sd139) $display("FAIL small_h0: got %0d required 139", h[0]);
    else pass_cnt++;
    total_cnt++;
    if (h[1] !== 16'sd10) $display("FAIL small_h1: got %0d required 10", h[1]);
    else pass_cnt++;
    bad = -1;
    for (int k = 0; k < 256; k++) if (bad < 0 && h[k] !== exp_h[k]) bad = k;
    total_cnt++;
    if (bad >= 0) $display("FAIL small_h: h[%0d]=%0d required %0d", bad, h[bad], exp_h[bad]);
    else pass_cnt++;
  endtask

  task automatic test_all_max();
    int   lat;
    int   bad;
    logic b0;
    for (int k = 0; k < 256; k++) begin
      f[k] = 16'sd3328;
      g[k] = 16'sd3328;
    end
    for (int i = 0; i < 128; i++) begin
      exp_h[2*i]   = 16'((1 + gamma_ref(i)) % 3329);
      exp_h[2*i+1] = 16'sd2;
    end
    run_job(lat, b0);
    total_cnt++;
    if (h[0] !== 16'sd18) $display("FAIL max_h0: got %0d required 18", h[0]);
    else pass_cnt++;
    total_cnt++;
    if (h[2] !== 16'sd3313) $display("FAIL max_h2: got %0d required 3313", h[2]);
    else pass_cnt++;
    total_cnt++;
    if (h[4] !== 16'sd2762) $display("FAIL max_h4: got %0d required 2762", h[4]);
    else pass_cnt++;
    total_cnt++;
    if (h[6] !== 16'sd569) $display("FAIL max_h6: got %0d required 569", h[6]);
    else pass_cnt++;
    total_cnt++;
    if (h[10] !== 16'sd2747) $display("FAIL max_h10: got %0d required 2747", h[10]);
    else pass_cnt++;
    bad = -1;
    for (int k = 0; k < 256; k++) if (bad < 0 && h[k] !== exp_h[k]) bad = k;
    total_cnt++;
    if (bad >= 0) $display("FAIL max_h: h[%0d]=%0d required %0d", bad, h[bad], exp_h[bad]);
    else pass_cnt++;
  endtask

  task automatic test_reset_mid_run();
    int   lat;
    int   bad;
    logic b0;
    @(negedge clk);
    start = 1'b1;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    repeat (100) @(posedge clk);
    @(negedge clk);
    reset = 1'b1;
    #1;
    total_cnt++;
    if (busy !== 1'b0) $display("FAIL midrst_busy: got %b required 0", busy);
    else pass_cnt++;
    total_cnt++;
    if (done !== 1'b0) $display("FAIL midrst_done: got %b required 0", done);
    else pass_cnt++;
    bad = -1;
    for (int k = 0; k < 256; k++) if (bad < 0 && h[k] !== 16'sd0) bad = k;
    total_cnt++;
    if (bad >= 0) $display("FAIL midrst_h: h[%0d]=%0d required 0", bad, h[bad]);
    else pass_cnt++;
    @(negedge clk);
    reset = 1'b0;
    load_small();
    run_job(lat, b0);
    total_cnt++;
    if (lat != 385) $display("FAIL midrst_latency: got %0d cycles required 385", lat);
    else pass_cnt++;
    bad = -1;
    for (int k = 0; k < 256; k++) if (bad < 0 && h[k] !== exp_h[k]) bad = k;
    total_cnt++;
    if (bad >= 0) $display("FAIL midrst_h_after: h[%0d]=%0d required %0d", bad, h[bad],
                           exp_h[bad]);
    else pass_cnt++;
  endtask

  task automatic test_back_to_back();
    int d_cyc [2];
    int n_done;
    int bad;
    clear_vectors();
    f[1] = 16'sd1; g[1] = 16'sd1;
    f[3] = 16'sd1; g[3] = 16'sd1;
    exp_h[0] = 16'sd17;
    exp_h[2] = 16'sd3312;
    d_cyc[0] = -1;
    d_cyc[1] = -1;
    n_done = 0;
    @(negedge clk);
    start = 1'b1;
    @(posedge clk);
    for (int cyc = 1; cyc <= 800; cyc++) begin
      @(posedge clk);
      @(negedge clk);
      if (done) begin
        if (n_done < 2) d_cyc[n_done] = cyc;
        n_done++;
        bad = -1;
        for (int k = 0; k < 256; k++) if (bad < 0 && h[k] !== exp_h[k]) bad = k;
        total_cnt++;
        if (bad >= 0) $display("FAIL b2b_h_run%0d: h[%0d]=%0d required %0d", n_done, bad,
                               h[bad], exp_h[bad]);
        else pass_cnt++;
      end
    end
    start = 1'b0;
    total_cnt++;
    if (n_done != 2) $display("FAIL b2b_count: got %0d done pulses required 2", n_done);
    else pass_cnt++;
    total_cnt++;
    if (d_cyc[0] != 385) $display("FAIL b2b_first: got cycle %0d required 385", d_cyc[0]);
    else pass_cnt++;
    total_cnt++;
    if (d_cyc[1] - d_cyc[0] != 386)
      $display("FAIL b2b_period: got %0d cycles required 386", d_cyc[1] - d_cyc[0]);
    else pass_cnt++;
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
  endtask

  initial begin
    pass_cnt  = 0;
    total_cnt = 0;
    reset     = 1'b1;
    start     = 1'b0;
    test_reset();
    test_unit();
    test_gamma_pairs();
    test_small();
    test_all_max();
    test_reset_mid_run();
    test_back_to_back();
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
